// File: rtl/cursor_pkg.sv
// cursor_pkg: opcode encoding and FSM state type shared by the cursor controller and its users.
// Opcodes are 4 bits wide. Values with no meaning assigned here are accepted and treated as NOP.
// Ports: none (package).
package cursor_pkg;

  localparam int OP_BITS = 4;
  typedef logic [OP_BITS-1:0] op_t;

  localparam op_t OP_NOP   = 4'd0;
  localparam op_t OP_SET   = 4'd1;
  localparam op_t OP_HOME  = 4'd2;
  localparam op_t OP_CR    = 4'd3;
  localparam op_t OP_LF    = 4'd4;
  localparam op_t OP_RIGHT = 4'd5;
  localparam op_t OP_BS    = 4'd6;
  localparam op_t OP_TAB   = 4'd7;
  localparam op_t OP_UP    = 4'd8;
  localparam op_t OP_DOWN  = 4'd9;

  typedef enum logic {
    IDLE   = 1'b0,
    SCROLL = 1'b1
  } state_t;

endpackage

// File: rtl/cursor_ctrl_if.sv
// cursor_ctrl_if: command channel (valid/ready) and scroll channel (req/ack) of the cursor controller.
// master = command producer / text buffer side, slave = cursor_ctrl.
// Signals: cmd_valid, cmd_ready, cmd_op, cmd_x, cmd_y, scroll_req, scroll_ack.
interface cursor_ctrl_if #(
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 5
);
  import cursor_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  op_t                 cmd_op;
  logic [COL_BITS-1:0] cmd_x;
  logic [ROW_BITS-1:0] cmd_y;
  logic                scroll_req;
  logic                scroll_ack;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, scroll_ack,
    input  cmd_ready, scroll_req
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, scroll_ack,
    output cmd_ready, scroll_req
  );

endinterface

// File: rtl/cursor_ctrl_blink_timer.sv
// blink_timer: counts tick pulses and toggles blink_on every BLINK_TICKS ticks.
// Latency: blink_on is registered; restart/enable take effect on the next edge.
// Ports: clk, reset (sync, high), tick (pulse), enable (0 = steady on), restart (clear + show), blink_on.
module blink_timer #(
  parameter int BLINK_TICKS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic enable,
  input  logic restart,
  output logic blink_on
);

  // Keep a 1-bit counter when BLINK_TICKS is 1 so the declaration stays legal;
  // the counter then sits at 0 and every tick hits the wrap condition.
  localparam int CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_TICKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      blink_on <= 1'b1;
    end else if (!enable || restart) begin
      // Restart beats a coincident tick so the cursor is visible right after typing.
      cnt      <= '0;
      blink_on <= 1'b1;
    end else if (tick) begin
      if (cnt == LAST) begin
        cnt      <= '0;
        blink_on <= ~blink_on;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: command-driven text cursor with line wrap, scroll request and blink.
// Latency: x/y update one edge after an accepted command; scroll_req rises on that same edge.
// Backpressure: cmd_ready is low while a scroll is outstanding; producer must hold cmd_valid.
// Ports: clk, reset (sync, high), tick, blink_en, bus (cmd valid/ready + scroll req/ack), x, y, blink_on.
module cursor_ctrl
  import cursor_pkg::*;
#(
  parameter int ROW_BITS    = 5,
  parameter int COL_BITS    = 7,
  parameter int COLS        = 80,
  parameter int ROWS        = 25,
  parameter int BLINK_TICKS = 16,
  parameter int TAB_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                blink_en,
  cursor_ctrl_if.slave        bus,
  output logic [COL_BITS-1:0] x,
  output logic [ROW_BITS-1:0] y,
  output logic                blink_on
);

  localparam logic [COL_BITS-1:0] X_MAX    = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] Y_MAX    = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] TAB_MASK = COL_BITS'(TAB_WIDTH - 1);

  state_t              state;
  logic                cmd_ready_q;
  logic                scroll_req_q;
  logic                accept;
  logic [COL_BITS-1:0] nx;
  logic [ROW_BITS-1:0] ny;
  logic                scroll_hit;
  // One extra bit: the next tab stop after the last one can equal 2**COL_BITS.
  logic [COL_BITS:0]   tab_x;

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.scroll_req = scroll_req_q;
  assign accept         = bus.cmd_valid && cmd_ready_q;

  // Next position for the presented command, plus whether it runs off the bottom.
  always_comb begin
    nx         = x;
    ny         = y;
    scroll_hit = 1'b0;
    tab_x      = {1'b0, x | TAB_MASK} + (COL_BITS + 1)'(1);
    case (bus.cmd_op)
      OP_SET: begin
        nx = (bus.cmd_x > X_MAX) ? X_MAX : bus.cmd_x;
        ny = (bus.cmd_y > Y_MAX) ? Y_MAX : bus.cmd_y;
      end
      OP_HOME: begin
        nx = '0;
        ny = '0;
      end
      OP_CR: nx = '0;
      OP_RIGHT: begin
        if (x == X_MAX) begin
          // Wrap to column 0 and perform the implied line feed.
          nx = '0;
          if (y == Y_MAX) scroll_hit = 1'b1;
          else            ny = y + ROW_BITS'(1);
        end else begin
          nx = x + COL_BITS'(1);
        end
      end
      OP_LF: begin
        if (y == Y_MAX) scroll_hit = 1'b1;
        else            ny = y + ROW_BITS'(1);
      end
      OP_BS:   if (x != '0) nx = x - COL_BITS'(1);
      OP_TAB:  nx = (tab_x > {1'b0, X_MAX}) ? X_MAX : tab_x[COL_BITS-1:0];
      OP_UP:   if (y != '0) ny = y - ROW_BITS'(1);
      OP_DOWN: if (y != Y_MAX) ny = y + ROW_BITS'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      cmd_ready_q  <= 1'b1;
      scroll_req_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x <= nx;
            y <= ny;
            if (scroll_hit) begin
              state        <= SCROLL;
              cmd_ready_q  <= 1'b0;
              scroll_req_q <= 1'b1;
            end
          end
        end
        SCROLL: begin
          // Position is already final; only wait for the buffer to finish.
          if (bus.scroll_ack) begin
            state        <= IDLE;
            cmd_ready_q  <= 1'b1;
            scroll_req_q <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          cmd_ready_q  <= 1'b1;
          scroll_req_q <= 1'b0;
        end
      endcase
    end
  end

  blink_timer #(
    .BLINK_TICKS(BLINK_TICKS)
  ) u_blink (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .enable   (blink_en),
    .restart  (accept),
    .blink_on (blink_on)
  );

endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: scenario tasks driving cursor_ctrl with default parameters (80x25, 16-tick blink, tab 8).
// Each accepted command pushes its expected x/y/scroll_req onto a queue; the value is popped and
// compared once the DUT has taken the edge. Inputs change and outputs are sampled on negedge.
module tb_cursor_ctrl;
  import cursor_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       blink_en;
  logic [6:0] x;
  logic [4:0] y;
  logic       blink_on;

  always #5 clk = ~clk;

  cursor_ctrl_if #(.COL_BITS(7), .ROW_BITS(5)) bus ();

  cursor_ctrl #(
    .ROW_BITS(5), .COL_BITS(7), .COLS(80), .ROWS(25), .BLINK_TICKS(16), .TAB_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .blink_en(blink_en),
    .bus(bus), .x(x), .y(y), .blink_on(blink_on)
  );

  typedef struct {
    logic [6:0] x;
    logic [4:0] y;
    logic       sreq;
  } exp_t;

  typedef struct {
    op_t op;
    int  cx, cy, ex, ey;
  } step_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Present one command for a single edge (caller is at a negedge, ready is high).
  task automatic issue(input op_t op, input int cx, input int cy,
                       input int ex, input int ey, input logic es);
    exp_t e;
    bus.cmd_op    = op;
    bus.cmd_x     = cx[6:0];
    bus.cmd_y     = cy[4:0];
    bus.cmd_valid = 1'b1;
    e.x = ex[6:0]; e.y = ey[4:0]; e.sreq = es;
    sb.push_back(e);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; tick = 1'b0; blink_en = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_x = '0; bus.cmd_y = '0; bus.scroll_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (x !== 7'd0) begin n_bad++; $display("FAIL reset_x got=%0d want=0", x); end
    n_cmp++; if (y !== 5'd0) begin n_bad++; $display("FAIL reset_y got=%0d want=0", y); end
    n_cmp++; if (blink_on !== 1'b1) begin n_bad++; $display("FAIL reset_blink got=%b want=1", blink_on); end
    n_cmp++; if (bus.scroll_req !== 1'b0) begin n_bad++; $display("FAIL reset_sreq got=%b want=0", bus.scroll_req); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", bus.cmd_ready); end
  endtask

  task automatic test_blink;
    ticks(15);
    n_cmp++; if (blink_on !== 1'b1) begin n_bad++; $display("FAIL blink_t15 got=%b want=1", blink_on); end
    ticks(1);
    n_cmp++; if (blink_on !== 1'b0) begin n_bad++; $display("FAIL blink_t16 got=%b want=0", blink_on); end
    ticks(15);
    n_cmp++; if (blink_on !== 1'b0) begin n_bad++; $display("FAIL blink_t31 got=%b want=0", blink_on); end
    ticks(1);
    n_cmp++; if (blink_on !== 1'b1) begin n_bad++; $display("FAIL blink_t32 got=%b want=1", blink_on); end
    n_cmp++; if (x !== 7'd0 || y !== 5'd0) begin n_bad++; $display("FAIL blink_pos got=%0d,%0d want=0,0", x, y); end
  endtask

  // Operands of 200/40 do not fit 7/5-bit fields; 127/31 are the largest out-of-range values.
  task automatic test_scroll_right;
    exp_t e;
    issue(OP_SET, 127, 31, 79, 24, 1'b0);
    e = sb.pop_front();
    n_cmp++; if (x !== e.x || y !== e.y || bus.scroll_req !== e.sreq) begin
      n_bad++; $display("FAIL set_clamp got=%0d,%0d,%b want=%0d,%0d,%b", x, y, bus.scroll_req, e.x, e.y, e.sreq); end
    issue(OP_RIGHT, 0, 0, 0, 24, 1'b1);
    e = sb.pop_front();
    n_cmp++; if (x !== e.x || y !== e.y || bus.scroll_req !== e.sreq) begin
      n_bad++; $display("FAIL right_wrap got=%0d,%0d,%b want=%0d,%0d,%b", x, y, bus.scroll_req, e.x, e.y, e.sreq); end
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL right_ready got=%b want=0", bus.cmd_ready); end
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.scroll_req !== 1'b1) begin n_bad++; $display("FAIL sreq_held got=%b want=1", bus.scroll_req); end
    bus.scroll_ack = 1'b1;
    @(negedge clk);
    bus.scroll_ack = 1'b0;
    n_cmp++; if (bus.scroll_req !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL ack_release got sreq=%b ready=%b want 0,1", bus.scroll_req, bus.cmd_ready); end
  endtask

  task automatic test_tab_bs;
    exp_t  e;
    step_t t[8] = '{
      '{OP_SET, 10, 3, 10, 3}, '{OP_TAB, 0, 0, 16, 3},
      '{OP_SET, 77, 3, 77, 3}, '{OP_TAB, 0, 0, 79, 3},
      '{OP_SET,  1, 3,  1, 3}, '{OP_BS,  0, 0,  0, 3},
      '{OP_BS,   0, 0,  0, 3}, '{OP_BS,  0, 0,  0, 3}};
    foreach (t[i]) begin
      issue(t[i].op, t[i].cx, t[i].cy, t[i].ex, t[i].ey, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (x !== e.x || y !== e.y || bus.scroll_req !== e.sreq) begin
        n_bad++; $display("FAIL tab_bs[%0d] got=%0d,%0d,%b want=%0d,%0d,%b", i, x, y, bus.scroll_req, e.x, e.y, e.sreq); end
    end
  endtask

  task automatic test_moves;
    exp_t  e;
    step_t t[13] = '{
      '{OP_SET,   5, 0, 5, 0}, '{OP_UP,    0, 0, 5, 0}, '{OP_DOWN, 0, 0, 5, 1},
      '{OP_CR,    0, 0, 0, 1}, '{OP_RIGHT, 0, 0, 1, 1}, '{OP_LF,   0, 0, 1, 2},
      '{4'hF,    50, 9, 1, 2}, '{OP_HOME,  0, 0, 0, 0}, '{OP_SET, 79, 5, 79, 5},
      '{OP_RIGHT, 0, 0, 0, 6}, '{OP_SET,   3, 24, 3, 24}, '{OP_DOWN, 0, 0, 3, 24},
      '{OP_NOP,  9, 9, 3, 24}};
    foreach (t[i]) begin
      issue(t[i].op, t[i].cx, t[i].cy, t[i].ex, t[i].ey, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (x !== e.x || y !== e.y || bus.scroll_req !== e.sreq || bus.cmd_ready !== 1'b1) begin
        n_bad++; $display("FAIL moves[%0d] got=%0d,%0d,%b rdy=%b want=%0d,%0d,%b rdy=1",
                          i, x, y, bus.scroll_req, bus.cmd_ready, e.x, e.y, e.sreq); end
    end
  endtask

  task automatic test_held_lf;
    exp_t e;
    issue(OP_SET, 0, 24, 0, 24, 1'b0);
    e = sb.pop_front();
    n_cmp++; if (x !== e.x || y !== e.y) begin n_bad++; $display("FAIL held_set got=%0d,%0d want=%0d,%0d", x, y, e.x, e.y); end
    bus.cmd_op = OP_LF; bus.cmd_valid = 1'b1;
    e.x = 7'd0; e.y = 5'd24; e.sreq = 1'b1; sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if (x !== e.x || y !== e.y || bus.scroll_req !== e.sreq || bus.cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL held_lf got=%0d,%0d,%b rdy=%b want=%0d,%0d,%b rdy=0", x, y, bus.scroll_req, bus.cmd_ready, e.x, e.y, e.sreq); end
    repeat (4) begin
      @(negedge clk);
      n_cmp++; if (x !== 7'd0 || y !== 5'd24 || bus.cmd_ready !== 1'b0) begin
        n_bad++; $display("FAIL held_stall got=%0d,%0d rdy=%b want=0,24 rdy=0", x, y, bus.cmd_ready); end
    end
    bus.scroll_ack = 1'b1;
    @(negedge clk);
    bus.scroll_ack = 1'b0;
    n_cmp++; if (bus.cmd_ready !== 1'b1 || bus.scroll_req !== 1'b0) begin
      n_bad++; $display("FAIL held_idle got rdy=%b sreq=%b want 1,0", bus.cmd_ready, bus.scroll_req); end
    // The still-held LF is taken on the next edge and scrolls again.
    e.x = 7'd0; e.y = 5'd24; e.sreq = 1'b1; sb.push_back(e);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (x !== e.x || y !== e.y || bus.scroll_req !== e.sreq || bus.cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL held_accept got=%0d,%0d,%b rdy=%b want=%0d,%0d,%b rdy=0", x, y, bus.scroll_req, bus.cmd_ready, e.x, e.y, e.sreq); end
    bus.scroll_ack = 1'b1;
    @(negedge clk);
    bus.scroll_ack = 1'b0;
  endtask

  task automatic test_blink_restart;
    exp_t e;
    issue(OP_SET, 0, 0, 0, 0, 1'b0);
    e = sb.pop_front();
    n_cmp++; if (x !== e.x || y !== e.y) begin n_bad++; $display("FAIL br_set got=%0d,%0d want=%0d,%0d", x, y, e.x, e.y); end
    ticks(15);
    n_cmp++; if (blink_on !== 1'b1) begin n_bad++; $display("FAIL br_pre got=%b want=1", blink_on); end
    // Tick at counter 15 coincides with an accepted NOP: the NOP wins.
    tick = 1'b1; bus.cmd_op = OP_NOP; bus.cmd_valid = 1'b1;
    e.x = 7'd0; e.y = 5'd0; e.sreq = 1'b0; sb.push_back(e);
    @(negedge clk);
    tick = 1'b0; bus.cmd_valid = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (blink_on !== 1'b1 || x !== e.x || y !== e.y) begin
      n_bad++; $display("FAIL br_nop got blink=%b pos=%0d,%0d want 1,%0d,%0d", blink_on, x, y, e.x, e.y); end
    ticks(15);
    n_cmp++; if (blink_on !== 1'b1) begin n_bad++; $display("FAIL br_cnt15 got=%b want=1", blink_on); end
    ticks(1);
    n_cmp++; if (blink_on !== 1'b0) begin n_bad++; $display("FAIL br_cnt16 got=%b want=0", blink_on); end
    blink_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (blink_on !== 1'b1) begin n_bad++; $display("FAIL steady_force got=%b want=1", blink_on); end
    for (int i = 0; i < 40; i++) begin
      ticks(1);
      n_cmp++; if (blink_on !== 1'b1) begin n_bad++; $display("FAIL steady[%0d] got=%b want=1", i, blink_on); end
    end
    blink_en = 1'b1;
  endtask

  task automatic test_reset_in_scroll;
    exp_t e;
    issue(OP_SET, 79, 24, 79, 24, 1'b0);
    e = sb.pop_front();
    n_cmp++; if (x !== e.x || y !== e.y) begin n_bad++; $display("FAIL rs_set got=%0d,%0d want=%0d,%0d", x, y, e.x, e.y); end
    issue(OP_RIGHT, 0, 0, 0, 24, 1'b1);
    e = sb.pop_front();
    n_cmp++; if (bus.scroll_req !== e.sreq || x !== e.x || y !== e.y) begin
      n_bad++; $display("FAIL rs_enter got=%0d,%0d,%b want=%0d,%0d,%b", x, y, bus.scroll_req, e.x, e.y, e.sreq); end
    ticks(3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (bus.scroll_req !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL rs_fsm got sreq=%b rdy=%b want 0,1", bus.scroll_req, bus.cmd_ready); end
    n_cmp++; if (x !== 7'd0 || y !== 5'd0 || blink_on !== 1'b1) begin
      n_bad++; $display("FAIL rs_pos got=%0d,%0d blink=%b want 0,0,1", x, y, blink_on); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_blink();
    test_scroll_right();
    test_tab_bs();
    test_moves();
    test_held_lf();
    test_blink_restart();
    test_reset_in_scroll();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
